// File: rtl/mem_pkg.sv
// Shared definitions for the data RAM.
// Covers the word and lane types and the byte insert/extract helpers
// used by the read mux and the write-merge path.
package mem_pkg;

    localparam int WORD_BYTES = 4;
    localparam int BYTE_W     = 8;

    typedef logic [1:0]                       lane_t;
    typedef logic [WORD_BYTES*BYTE_W-1:0]     word_t;
    typedef logic [BYTE_W-1:0]                byte_t;

    // Return old_word with the little-endian lane replaced by new_byte.
    function automatic word_t byte_merge(input word_t old_word,
                                         input byte_t new_byte,
                                         input lane_t lane);
        word_t w;
        w = old_word;
        w[{lane, 3'b000} +: BYTE_W] = new_byte;
        return w;
    endfunction

    // Return the little-endian lane of word.
    function automatic byte_t byte_extract(input word_t word,
                                           input lane_t lane);
        return word[{lane, 3'b000} +: BYTE_W];
    endfunction

endpackage

// File: rtl/data_mem.sv
// Word-organised, byte-addressable data RAM.
// The read port is combinational. The write port is clocked and can write
// either a full word or a single byte lane. An asynchronous reset clears
// the whole array.
module data_mem
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int MEM_SIZE      = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDRESS_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0]    WD,
    input  logic                     WE,
    input  logic                     BE,
    output logic [DATA_WIDTH-1:0]    RD
);

    localparam int                       IDX_W      = $clog2(MEM_SIZE);
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_LIMIT = ADDRESS_WIDTH'(WORD_BYTES * MEM_SIZE);

    word_t            mem_q [MEM_SIZE];

    logic [IDX_W-1:0] idx;
    lane_t            lane;
    logic             in_range;
    word_t            cur_word;

    logic             wr_en_d;
    word_t            wr_word_d;

    // Decode the byte address into a word index and a lane, and fetch the addressed word.
    always_comb begin
        idx      = A[IDX_W+1:2];
        lane     = A[1:0];
        in_range = (A < ADDR_LIMIT);
        cur_word = mem_q[idx];
    end

    // Build the word to store. Byte mode merges one lane into the current contents.
    always_comb begin
        wr_en_d   = WE && in_range && !rst;
        wr_word_d = BE ? byte_merge(cur_word, WD[7:0], lane) : word_t'(WD);
    end

    // Storage array: clear everything on reset, otherwise write the addressed word.
    // NOTE: this RAM is cleared by reset on purpose, because the processor relies on
    // zeroed data memory. Resetting an array forces flops instead of a RAM macro, so
    // do not copy this pattern into memories that do not need it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MEM_SIZE; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_d) begin
            // NOTE: state is updated with non-blocking assignments, so every reader in
            // this edge sees the pre-edge contents. That is why there is no write-through.
            mem_q[idx] <= wr_word_d;
        end
    end

    // Read mux: word or zero-extended byte. Returns 0 when out of range or while in reset.
    always_comb begin
        // NOTE: the default assignment comes first, so no path leaves RD unassigned
        // and no latch is inferred.
        RD = '0;
        if (!rst && in_range) begin
            if (BE) begin
                RD = DATA_WIDTH'({24'b0, byte_extract(cur_word, lane)});
            end else begin
                RD = DATA_WIDTH'(cur_word);
            end
        end
    end

endmodule

// File: tb/tb_data_mem.sv
// Self-checking bench for data_mem. It runs the directed cases first and
// then a randomized run. The bench holds its own reference model: a flat
// byte-addressed array that is read and written with plain address arithmetic.
module tb_data_mem;

    localparam int MEM_SIZE = 1024;
    localparam int N_BYTES  = 4 * MEM_SIZE;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] A;
    logic [31:0] WD;
    logic        WE;
    logic        BE;
    logic [31:0] RD;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] model_mem [N_BYTES];

    data_mem #(
        .DATA_WIDTH   (32),
        .ADDRESS_WIDTH(32),
        .MEM_SIZE     (MEM_SIZE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .A  (A),
        .WD (WD),
        .WE (WE),
        .BE (BE),
        .RD (RD)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (A=0x%08h BE=%0b)", tag, got, exp, A, BE);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < N_BYTES; i++) model_mem[i] = 8'h00;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a, input logic be);
        logic [31:0] base;
        if (a >= 32'(N_BYTES)) return 32'h0;
        if (be) return {24'h0, model_mem[a]};
        base = a & ~32'h3;
        return {model_mem[base + 3], model_mem[base + 2], model_mem[base + 1], model_mem[base]};
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [31:0] wd, input logic be);
        logic [31:0] base;
        if (a >= 32'(N_BYTES)) return;
        if (be) begin
            model_mem[a] = wd[7:0];
        end else begin
            base = a & ~32'h3;
            for (int k = 0; k < 4; k++) model_mem[base + k] = wd[8*k +: 8];
        end
    endfunction

    // Present a write at a negedge. Before the edge, RD must still show the old contents.
    // Then pass one rising edge and check the new contents.
    task automatic do_write(input logic [31:0] a, input logic [31:0] wd, input logic be);
        @(negedge clk);
        A = a; WD = wd; BE = be; WE = 1'b1;
        #1;
        check("pre_edge_old_value", RD, model_read(a, be));
        @(posedge clk);
        model_write(a, wd, be);
        #1;
        WE = 1'b0;
        check("post_edge_new_value", RD, model_read(a, be));
    endtask

    task automatic do_read(input string tag, input logic [31:0] a, input logic be);
        @(negedge clk);
        A = a; BE = be; WE = 1'b0;
        #1;
        check(tag, RD, model_read(a, be));
    endtask

    // Fixed expectations from hand-worked cases; these do not come from the model.
    task automatic expect_read(input string tag, input logic [31:0] a, input logic be, input logic [31:0] exp);
        @(negedge clk);
        A = a; BE = be; WE = 1'b0;
        #1;
        check(tag, RD, exp);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] wd;
        logic        be;
        int          r;

        rst = 1'b1; A = '0; WD = '0; WE = 1'b0; BE = 1'b0;
        model_clear();
        #1;
        check("rd_during_reset", RD, 32'h0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // Reset then word read
        for (int i = 0; i < 10; i++) expect_read("reset_word_read", 32'(4 * i), 1'b0, 32'h0);

        // Word write then read
        do_write(32'h24, 32'h52, 1'b0);
        expect_read("word_rd_0x24", 32'h24, 1'b0, 32'h0000_0052);
        expect_read("word_rd_0x20", 32'h20, 1'b0, 32'h0);

        // Unaligned word write
        do_write(32'h2, 32'h11, 1'b0);
        expect_read("unaligned_rd_0", 32'h0, 1'b0, 32'h0000_0011);
        expect_read("unaligned_rd_4", 32'h4, 1'b0, 32'h0);

        // Byte writes into a known word
        do_write(32'h0, 32'h1122_3344, 1'b0);
        do_write(32'h0, 32'hAAAA_AAFE, 1'b1);
        do_write(32'h2, 32'h5555_554B, 1'b1);
        expect_read("byte_merge_word", 32'h0, 1'b0, 32'h114B_33FE);
        expect_read("byte_rd_lane0", 32'h0, 1'b1, 32'h0000_00FE);
        expect_read("byte_rd_lane1", 32'h1, 1'b1, 32'h0000_0033);
        expect_read("byte_rd_lane2", 32'h2, 1'b1, 32'h0000_004B);
        expect_read("byte_rd_lane3", 32'h3, 1'b1, 32'h0000_0011);

        // Byte read zero-extension
        do_write(32'h0, 32'h80FF_0000, 1'b0);
        expect_read("zext_lane2", 32'h2, 1'b1, 32'h0000_00FF);
        expect_read("zext_lane3", 32'h3, 1'b1, 32'h0000_0080);

        // WE held for several cycles rewrites the same value
        @(negedge clk);
        A = 32'h10; WD = 32'hCAFE_F00D; BE = 1'b0; WE = 1'b1;
        repeat (3) @(negedge clk);
        WE = 1'b0;
        model_write(32'h10, 32'hCAFE_F00D, 1'b0);
        expect_read("held_we", 32'h10, 1'b0, 32'hCAFE_F00D);
        expect_read("held_we_neighbour", 32'h14, 1'b0, 32'h0);

        // Reset mid-operation: RD drops without a clock edge
        do_write(32'h8, 32'hDEAD_BEEF, 1'b0);
        expect_read("pre_reset", 32'h8, 1'b0, 32'hDEAD_BEEF);
        #2;
        rst = 1'b1;
        model_clear();
        #1;
        check("async_reset_clear", RD, 32'h0);
        // Writes are blocked while reset is high
        WD = 32'h1234_5678; WE = 1'b1;
        @(posedge clk);
        #1;
        check("write_blocked_in_reset", RD, 32'h0);
        @(negedge clk);
        WE = 1'b0;
        rst = 1'b0;
        expect_read("after_reset_a8", 32'h8, 1'b0, 32'h0);
        expect_read("after_reset_a0", 32'h0, 1'b0, 32'h0);

        // Out of range: write ignored, read returns 0, no aliasing onto word 0
        do_write(32'h1000, 32'h0BAD_0BAD, 1'b0);
        expect_read("oor_read", 32'h1000, 1'b0, 32'h0);
        expect_read("oor_no_alias", 32'h0, 1'b0, 32'h0);
        do_write(32'h8000_0004, 32'h7777_7777, 1'b0);
        expect_read("oor_high_no_alias", 32'h4, 1'b0, 32'h0);
        expect_read("last_word_empty", 32'hFFC, 1'b0, 32'h0);
        do_write(32'hFFF, 32'h0000_00A5, 1'b1);
        expect_read("last_byte", 32'hFFC, 1'b0, 32'hA500_0000);

        // Randomized mix against the byte-array model
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 19);
            if (r == 0)      a = 32'h1000 + 32'($urandom_range(0, 255));
            else if (r == 1) a = $urandom | 32'h8000_0000;
            else if (r < 6)  a = 32'($urandom_range(0, 63));
            else             a = 32'($urandom_range(0, N_BYTES - 1));
            wd = $urandom;
            be = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) do_write(a, wd, be);
            do_read("rand_read", a, be);
            do_read("rand_read_word", a & 32'h0000_0FFC, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem.md
# data_mem

Word-organised, byte-addressable data RAM for the single-cycle processor datapath. It serves load/store accesses from the execute stage, with a combinational read port and a clocked write port. It supports full-word and single-byte accesses, selected by a byte-enable flag. Contents are cleared by an asynchronous reset.

## Interface
Parameters:
- DATA_WIDTH, 32: word width in bits; must be 32.
- ADDRESS_WIDTH, 32: byte-address width.
- MEM_SIZE, 1024: depth in words; power of two.

Ports:
- clk  in  1: sole clock; writes occur on the rising edge.
- rst  in  1: reset, asynchronous, active-high; clears every word to 0.
- A  in  ADDRESS_WIDTH: byte address.
- WD  in  DATA_WIDTH: write data.
- WE  in  1: write enable.
- BE  in  1: byte mode. 0 = 32-bit word access, 1 = 8-bit byte access.
- RD  out  DATA_WIDTH: read data, combinational.

## Operation
Addressing:
- Word index = A[log2(MEM_SIZE)+1:2].
- Byte lane = A[1:0]. Lanes are little-endian: lane 0 = bits [7:0] … lane 3 = bits [31:24].

Out-of-range accesses:
- An access is out of range when A >= 4*MEM_SIZE.
- Out-of-range reads return 0.
- Out-of-range writes are ignored.

Word mode (BE=0):
- Read: RD = mem[index]. A[1:0] is ignored, so unaligned addresses access the containing aligned word.
- Write (WE=1): mem[index] <= WD.

Byte mode (BE=1):
- Read: RD = {24'b0, selected lane}, zero-extended.
- Write (WE=1): only the selected lane <= WD[7:0]; the other three lanes are preserved. WD[31:8] is ignored.

## Timing
- Reset:
  - rst=1 forces all words to 0 immediately, independent of clk.
  - While rst is high, writes are blocked and RD reads 0.
  - Deasserting rst takes effect at the next rising edge; no extra cycles are needed.
- Read latency is zero. RD follows A, BE and the memory contents combinationally.
- A write issued at edge N:
  - is visible on RD immediately after edge N;
  - is not visible before edge N.
  - There is no read-during-write bypass; RD shows the old value until the edge.
- WE held for several cycles rewrites the same value each cycle, with no side effect.
- rst asserted on the same edge as a write: reset wins and the write is lost.

## Structure
- Shared package `mem_pkg`:
  - WORD_BYTES = 4.
  - Lane-index typedef (2 bits).
  - Function `byte_merge(old_word, byte, lane)` that returns the word with one lane replaced.
  - Function `byte_extract(word, lane)` that returns the selected byte.
- Sub-modules: none. Implement as a register array with one always_ff (async reset plus write) and one always_comb read mux.

## Test plan
- Reset then word read: pulse rst, read A=0,4,…,36 -> RD=0x00000000 each.
- Word write then read: WE=1 BE=0 A=0x24 WD=0x52 for one edge, then WE=0 A=0x24 -> RD=0x00000052. A=0x20 -> 0.
- Unaligned word write: WE=1 BE=0 A=2 WD=0x11, then read A=0 BE=0 -> 0x00000011. Read A=4 -> unchanged.
- Byte writes: word 0 = 0x11223344 (word write), then byte write A=0 WD=0xFE and byte write A=2 WD=0x4B.
  - Word read A=0 -> 0x114B33FE.
  - Byte reads A=0..3 -> 0xFE, 0x33, 0x4B, 0x11.
- Byte read zero-extension: word 0 = 0x80FF0000. Byte read A=2 -> 0x000000FF; A=3 -> 0x00000080.
- Reset mid-operation and range: write 0xDEADBEEF to A=8, assert rst between edges.
  - RD at A=8 drops to 0 without a clock edge.
  - After release, a write to A=4096 is ignored and a read of A=4096 returns 0.
